// File: rtl/if_fetch_unit_pkg.sv
// Shared uP16 definitions for the instruction fetch front end: widths, reset PC,
// fetch FSM encoding and a saturating counter helper.
`timescale 1ns/1ps
package uP16_define;

    localparam int ISIZE = 18;
    localparam int ASIZE = 10;
    localparam int CNT_W = 16;

    localparam logic [ASIZE-1:0] RESET_PC = 10'h000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_e;

    function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'h0001;
        end
        return result;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, hold freezes every
// field, otherwise the F2 word and its PCs are captured.
`timescale 1ns/1ps
module if_id_reg #(
    parameter int ISIZE = 18,
    parameter int ASIZE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic [ISIZE-1:0] instr_d,
    input  logic [ASIZE-1:0] pc_d,
    input  logic [ASIZE-1:0] pc_plus1_d,
    input  logic             valid_d,
    output logic [ISIZE-1:0] instr_q,
    output logic [ASIZE-1:0] pc_q,
    output logic [ASIZE-1:0] pc_plus1_q,
    output logic             valid_q
);

    // Pipeline register update: flush beats hold, hold beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= '0;
            pc_q       <= '0;
            pc_plus1_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
        end else if (hold) begin
            instr_q    <= instr_q;
            pc_q       <= pc_q;
            pc_plus1_q <= pc_plus1_q;
            valid_q    <= valid_q;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, drives the I_mem address and absorbs
// the one-cycle BRAM read latency. Optional counters under IF_PERF_CNT_EN.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter int ISIZE = uP16_define::ISIZE,
    parameter int ASIZE = uP16_define::ASIZE,
    parameter logic [ASIZE-1:0] RESET_PC = uP16_define::RESET_PC
) (
    input  logic             Clk_In,
    input  logic             Rst_In,
    input  logic             Stall_In,
    input  logic             Redirect_In,
    input  logic [ASIZE-1:0] Target_In,
    output logic [ASIZE-1:0] Imem_Addr_Out,
    input  logic [ISIZE-1:0] Imem_Data_In,
    output logic [ISIZE-1:0] Instr_Out,
    output logic [ASIZE-1:0] PC_Out,
    output logic [ASIZE-1:0] PC_Plus1_Out,
`ifdef IF_PERF_CNT_EN
    output logic [15:0]      Fetch_Cnt_Out,
    output logic [15:0]      Bubble_Cnt_Out,
`endif
    output logic             Valid_Out
);

    import uP16_define::fetch_state_e;
    import uP16_define::ST_BOOT;
    import uP16_define::ST_RUN;
    import uP16_define::ST_HOLD;

    localparam logic [ASIZE-1:0] PC_ONE = {{(ASIZE-1){1'b0}}, 1'b1};

    fetch_state_e     state_r;
    logic [ASIZE-1:0] pc_f2_r;
    logic             f2_valid_r;
    logic [ASIZE-1:0] next_pc_s;
    logic [ASIZE-1:0] pc_f2_plus1_s;

    assign pc_f2_plus1_s = pc_f2_r + PC_ONE;
    assign Imem_Addr_Out = next_pc_s;

    // Next fetch address: boot vector, then redirect, then re-read on stall, else sequential.
    always_comb begin
        next_pc_s = RESET_PC;
        if (state_r == ST_BOOT) begin
            next_pc_s = RESET_PC;
        end else if (Redirect_In) begin
            next_pc_s = Target_In;
        end else if (Stall_In) begin
            next_pc_s = pc_f2_r;
        end else begin
            next_pc_s = pc_f2_plus1_s;
        end
    end

    // Fetch FSM plus the F2 address tracker that tags the word arriving from I_mem.
    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            state_r    <= ST_BOOT;
            pc_f2_r    <= RESET_PC;
            f2_valid_r <= 1'b0;
        end else begin
            pc_f2_r    <= next_pc_s;
            f2_valid_r <= 1'b1;
            case (state_r)
                ST_BOOT: state_r <= ST_RUN;
                ST_RUN,
                ST_HOLD: state_r <= (Stall_In && !Redirect_In) ? ST_HOLD : ST_RUN;
                default: state_r <= ST_RUN;
            endcase
        end
    end

    if_id_reg #(
        .ISIZE (ISIZE),
        .ASIZE (ASIZE)
    ) u_if_id_reg (
        .clk        (Clk_In),
        .rst        (Rst_In),
        .flush      (Redirect_In),
        .hold       (Stall_In),
        .instr_d    (Imem_Data_In),
        .pc_d       (pc_f2_r),
        .pc_plus1_d (pc_f2_plus1_s),
        .valid_d    (f2_valid_r),
        .instr_q    (Instr_Out),
        .pc_q       (PC_Out),
        .pc_plus1_q (PC_Plus1_Out),
        .valid_q    (Valid_Out)
    );

`ifdef IF_PERF_CNT_EN
    import uP16_define::sat_inc16;

    logic        fetch_evt_s;
    logic        bubble_evt_s;
    logic [15:0] fetch_cnt_r;
    logic [15:0] bubble_cnt_r;

    // Mirror the IF/ID load decision: a bubble is a flush or an unqualified F2 word.
    assign fetch_evt_s  = !Redirect_In && !Stall_In && f2_valid_r;
    assign bubble_evt_s = Redirect_In || (!Stall_In && !f2_valid_r);

    // Saturating delivery and bubble counters.
    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            fetch_cnt_r  <= 16'h0000;
            bubble_cnt_r <= 16'h0000;
        end else begin
            if (fetch_evt_s) begin
                fetch_cnt_r <= sat_inc16(fetch_cnt_r);
            end
            if (bubble_evt_s) begin
                bubble_cnt_r <= sat_inc16(bubble_cnt_r);
            end
        end
    end

    assign Fetch_Cnt_Out  = fetch_cnt_r;
    assign Bubble_Cnt_Out = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural 1-cycle-latency ROM
// returning word[a] = {8'h00, a}.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [9:0]  target;
    logic [9:0]  imem_addr;
    logic [17:0] imem_data;
    logic [17:0] instr;
    logic [9:0]  pc;
    logic [9:0]  pc_plus1;
    logic        valid;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] bubble_cnt;
`endif

    int vec_cnt;
    int miscompare_cnt;

    if_fetch_unit dut (
        .Clk_In         (clk),
        .Rst_In         (rst),
        .Stall_In       (stall),
        .Redirect_In    (redirect),
        .Target_In      (target),
        .Imem_Addr_Out  (imem_addr),
        .Imem_Data_In   (imem_data),
        .Instr_Out      (instr),
        .PC_Out         (pc),
        .PC_Plus1_Out   (pc_plus1),
`ifdef IF_PERF_CNT_EN
        .Fetch_Cnt_Out  (fetch_cnt),
        .Bubble_Cnt_Out (bubble_cnt),
`endif
        .Valid_Out      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= {8'h00, imem_addr};

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [9:0] exp_pc,
                              input logic [9:0] exp_plus1, input logic [17:0] exp_instr);
        check_vec({tag, "_valid"}, 32'(valid), 32'h1);
        check_vec({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        check_vec({tag, "_pc1"}, 32'(pc_plus1), 32'(exp_plus1));
        check_vec({tag, "_instr"}, 32'(instr), 32'(exp_instr));
    endtask

    initial begin
        vec_cnt        = 0;
        miscompare_cnt = 0;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        target         = 10'h000;

        tick();
        tick();
        check_vec("rst_valid", 32'(valid), 32'h0);
        check_vec("rst_pc", 32'(pc), 32'h0);
        check_vec("rst_pc1", 32'(pc_plus1), 32'h0);
        check_vec("rst_instr", 32'(instr), 32'h0);
        check_vec("rst_addr", 32'(imem_addr), 32'h000);
`ifdef IF_PERF_CNT_EN
        check_vec("rst_fcnt", 32'(fetch_cnt), 32'h0);
        check_vec("rst_bcnt", 32'(bubble_cnt), 32'h0);
`endif

        // Test 1: boot and sequential fetch
        rst = 1'b0;
        #1;
        check_vec("boot_addr", 32'(imem_addr), 32'h000);
        tick();
        check_vec("edge1_valid", 32'(valid), 32'h0);
        check_vec("edge1_addr", 32'(imem_addr), 32'h001);
        tick();
        check_ifid("first", 10'h000, 10'h001, 18'h00000);
        check_vec("first_addr", 32'(imem_addr), 32'h002);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_ifid("seq", 10'(i), 10'(i + 1), 18'(i));
            check_vec("seq_addr", 32'(imem_addr), 32'(i + 2));
        end

        // Test 2: three stall cycles at PC_Out=005
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            check_vec("stall_addr", 32'(imem_addr), 32'h006);
            tick();
            check_ifid("stall_hold", 10'h005, 10'h006, 18'h00005);
        end
        stall = 1'b0;
        #1;
        check_vec("unstall_addr", 32'(imem_addr), 32'h007);
        for (int i = 6; i <= 16; i++) begin
            tick();
            check_ifid("resume", 10'(i), 10'(i + 1), 18'(i));
        end

        // Test 3: redirect to 100 at PC_Out=010
        redirect = 1'b1;
        target   = 10'h100;
        #1;
        check_vec("redir_addr", 32'(imem_addr), 32'h100);
        tick();
        redirect = 1'b0;
        check_vec("redir_bubble", 32'(valid), 32'h0);
        tick();
        check_ifid("redir_tgt", 10'h100, 10'h101, 18'h00100);
`ifdef IF_PERF_CNT_EN
        check_vec("bcnt_t3", 32'(bubble_cnt), 32'h2);
        check_vec("fcnt_t3", 32'(fetch_cnt), 32'd18);
`endif

        // Test 4: redirect and stall together, redirect wins
        redirect = 1'b1;
        stall    = 1'b1;
        target   = 10'h020;
        #1;
        check_vec("rs_addr", 32'(imem_addr), 32'h020);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check_vec("rs_bubble", 32'(valid), 32'h0);
        tick();
        check_ifid("rs_tgt", 10'h020, 10'h021, 18'h00020);

        // Test 5: PC wrap at the top of the address space
        redirect = 1'b1;
        target   = 10'h3FE;
        tick();
        redirect = 1'b0;
        check_vec("wrap_bubble", 32'(valid), 32'h0);
        tick();
        check_ifid("wrap_3fe", 10'h3FE, 10'h3FF, 18'h003FE);
        tick();
        check_ifid("wrap_3ff", 10'h3FF, 10'h000, 18'h003FF);
        tick();
        check_ifid("wrap_000", 10'h000, 10'h001, 18'h00000);

        // Test 6: asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check_vec("arst_valid", 32'(valid), 32'h0);
        check_vec("arst_pc", 32'(pc), 32'h0);
        check_vec("arst_pc1", 32'(pc_plus1), 32'h0);
        check_vec("arst_instr", 32'(instr), 32'h0);
        check_vec("arst_addr", 32'(imem_addr), 32'h000);
`ifdef IF_PERF_CNT_EN
        check_vec("arst_bcnt", 32'(bubble_cnt), 32'h0);
`endif
        tick();
        rst = 1'b0;
        tick();
        check_vec("reboot_valid", 32'(valid), 32'h0);
        tick();
        check_ifid("reboot", 10'h000, 10'h001, 18'h00000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
